// File: rtl/riscv_ctrl_pkg.sv
// Shared control-word layout, hart state encoding and control-word decode
// for the execution controller and its per-hart FSMs.
package riscv_ctrl_pkg;

  localparam int CTRL_RUN_BIT   = 0;
  localparam int CTRL_RESET_BIT = 1;
  localparam int CTRL_STEP_BIT  = 2;
  localparam int STEP_CNT_LSB   = 8;
  localparam int STEP_CNT_MSB   = 15;
  localparam int MASK_LSB       = 16;
  localparam int MASK_MSB       = 31;
  localparam int MAX_HARTS      = MASK_MSB - MASK_LSB + 1;

  localparam logic [1:0] ST_HALTED    = 2'd0;
  localparam logic [1:0] ST_RESETTING = 2'd1;
  localparam logic [1:0] ST_RUNNING   = 2'd2;
  localparam logic [1:0] ST_STEPPING  = 2'd3;

  typedef enum logic [1:0] {
    HART_HALTED    = ST_HALTED,
    HART_RESETTING = ST_RESETTING,
    HART_RUNNING   = ST_RUNNING,
    HART_STEPPING  = ST_STEPPING
  } hart_state_e;

  typedef struct packed {
    logic       run;
    logic       reset;
    logic       step;
    logic [7:0] step_cnt;
  } ctrl_cmd_t;

  function automatic ctrl_cmd_t decode_ctrl(input logic [31:0] word);
    ctrl_cmd_t cmd;
    cmd.run      = word[CTRL_RUN_BIT];
    cmd.reset    = word[CTRL_RESET_BIT];
    cmd.step     = word[CTRL_STEP_BIT];
    cmd.step_cnt = word[STEP_CNT_MSB:STEP_CNT_LSB];
    return cmd;
  endfunction

endpackage

// File: rtl/riscv_hart_fsm.sv
// Per-hart execution FSM: reset pulse counter, step counter and optional
// step watchdog (enabled by RISCV_EXEC_CTRL_STEP_WDOG_EN). All outputs registered.
module riscv_hart_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = 4,
  parameter int STEP_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  ctrl_cmd_t   cmd,
  input  logic        retire,
  input  logic        halt_req,
  output logic        core_en,
  output logic        core_rst,
  output logic        hart_halted,
  output logic        step_done,
  output logic        step_timeout,
  output hart_state_e state
);

  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  hart_state_e state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [8:0]       step_rem_q, step_rem_d;
  logic             run_lat_q, run_lat_d;
  logic             done_d;
  logic             tout_q, tout_d;

`ifdef RISCV_EXEC_CTRL_STEP_WDOG_EN
  localparam int WD_W = (STEP_TIMEOUT > 1) ? $clog2(STEP_TIMEOUT) : 1;
  logic [WD_W-1:0] wd_q, wd_d;
`else
  localparam int unused_step_timeout = STEP_TIMEOUT;
`endif

  // A selected write wins over halt_req, retire and the watchdog; a non-reset
  // write that lands during RESETTING is dropped and the pulse keeps counting.
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    step_rem_d = step_rem_q;
    run_lat_d  = run_lat_q;
    done_d     = 1'b0;
    tout_d     = tout_q;
`ifdef RISCV_EXEC_CTRL_STEP_WDOG_EN
    wd_d       = wd_q;
`endif
    if (cmd_valid) begin
      tout_d = 1'b0;
    end
    if (cmd_valid && cmd.reset) begin
      state_d   = HART_RESETTING;
      rst_cnt_d = RST_W'(RST_CYCLES - 1);
      run_lat_d = cmd.run;
    end else if (cmd_valid && (state_q != HART_RESETTING)) begin
      if (cmd.run) begin
        state_d = HART_RUNNING;
      end else if ((state_q == HART_HALTED) && cmd.step) begin
        state_d    = HART_STEPPING;
        step_rem_d = {1'b0, cmd.step_cnt} + 9'd1;
`ifdef RISCV_EXEC_CTRL_STEP_WDOG_EN
        wd_d       = '0;
`endif
      end else begin
        state_d = HART_HALTED;
      end
    end else begin
      case (state_q)
        HART_RESETTING: begin
          if (rst_cnt_q == '0) begin
            state_d = run_lat_q ? HART_RUNNING : HART_HALTED;
          end else begin
            rst_cnt_d = rst_cnt_q - RST_W'(1);
          end
        end
        HART_RUNNING: begin
          if (halt_req) begin
            state_d = HART_HALTED;
          end
        end
        HART_STEPPING: begin
          if (halt_req) begin
            state_d = HART_HALTED;
          end else if (retire) begin
            step_rem_d = step_rem_q - 9'd1;
`ifdef RISCV_EXEC_CTRL_STEP_WDOG_EN
            wd_d       = '0;
`endif
            if (step_rem_q == 9'd1) begin
              state_d = HART_HALTED;
              done_d  = 1'b1;
            end
          end
`ifdef RISCV_EXEC_CTRL_STEP_WDOG_EN
          else if (wd_q == WD_W'(STEP_TIMEOUT - 1)) begin
            state_d = HART_HALTED;
            tout_d  = 1'b1;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Outputs are flops loaded from the next-state decode so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HART_HALTED;
      rst_cnt_q   <= '0;
      step_rem_q  <= '0;
      run_lat_q   <= 1'b0;
      tout_q      <= 1'b0;
      core_en     <= 1'b0;
      core_rst    <= 1'b0;
      hart_halted <= 1'b1;
      step_done   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      step_rem_q  <= step_rem_d;
      run_lat_q   <= run_lat_d;
      tout_q      <= tout_d;
      core_en     <= (state_d == HART_RUNNING) || (state_d == HART_STEPPING);
      core_rst    <= (state_d == HART_RESETTING);
      hart_halted <= (state_d == HART_HALTED);
      step_done   <= done_d;
    end
  end

`ifdef RISCV_EXEC_CTRL_STEP_WDOG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
  assign step_timeout = tout_q;
`else
  assign step_timeout = 1'b0;
`endif

  assign state = state_q;

endmodule

// File: rtl/riscv_exec_ctrl.sv
// Multi-hart execution controller: decodes control-word writes into per-hart
// commands. Optional step watchdog via RISCV_EXEC_CTRL_STEP_WDOG_EN.
module riscv_exec_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int NUM_HARTS    = 2,
  parameter int RST_CYCLES   = 4,
  parameter int STEP_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ctrl_we,
  input  logic [31:0]            ctrl_wdata,
  input  logic [NUM_HARTS-1:0]   hart_retire,
  input  logic [NUM_HARTS-1:0]   halt_req,
  output logic [NUM_HARTS-1:0]   core_en,
  output logic [NUM_HARTS-1:0]   core_rst,
  output logic [NUM_HARTS-1:0]   hart_halted,
  output logic [NUM_HARTS-1:0]   step_done,
  output logic [NUM_HARTS-1:0]   step_timeout,
  output logic [2*NUM_HARTS-1:0] dbg_state
);

  ctrl_cmd_t              cmd;
  logic [MAX_HARTS-1:0]   mask_field;
  logic [NUM_HARTS-1:0]   hart_sel;
  logic [47:0]            unused_bits;

  assign cmd         = decode_ctrl(ctrl_wdata);
  assign mask_field  = ctrl_wdata[MASK_MSB:MASK_LSB];
  // Mask bits above NUM_HARTS have no hart behind them and are dropped here.
  assign hart_sel    = {NUM_HARTS{ctrl_we}} & mask_field[NUM_HARTS-1:0];
  assign unused_bits = {ctrl_wdata, mask_field};

  for (genvar i = 0; i < NUM_HARTS; i++) begin : g_hart
    hart_state_e st;

    riscv_hart_fsm #(
      .RST_CYCLES   (RST_CYCLES),
      .STEP_TIMEOUT (STEP_TIMEOUT)
    ) u_fsm (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (hart_sel[i]),
      .cmd          (cmd),
      .retire       (hart_retire[i]),
      .halt_req     (halt_req[i]),
      .core_en      (core_en[i]),
      .core_rst     (core_rst[i]),
      .hart_halted  (hart_halted[i]),
      .step_done    (step_done[i]),
      .step_timeout (step_timeout[i]),
      .state        (st)
    );

    assign dbg_state[2*i +: 2] = st;
  end

endmodule

// File: tb/tb_riscv_exec_ctrl.sv
// Directed plus randomized bench for riscv_exec_ctrl against a cycle-level
// behavioural model of the hart control rules.
module tb_riscv_exec_ctrl;

  localparam int NH = 2;
  localparam int RC = 4;
`ifdef RISCV_EXEC_CTRL_STEP_WDOG_EN
  localparam int STO = 16;
`else
  localparam int STO = 1024;
`endif

  localparam int M_HALT = 0;
  localparam int M_RST  = 1;
  localparam int M_RUN  = 2;
  localparam int M_STEP = 3;

  logic          clk;
  logic          rst_n;
  logic          ctrl_we;
  logic [31:0]   ctrl_wdata;
  logic [NH-1:0] hart_retire;
  logic [NH-1:0] halt_req;
  logic [NH-1:0] core_en;
  logic [NH-1:0] core_rst;
  logic [NH-1:0] hart_halted;
  logic [NH-1:0] step_done;
  logic [NH-1:0] step_timeout;
  logic [2*NH-1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  int m_mode[NH];
  int m_rst_left[NH];
  bit m_latch[NH];
  int m_steps[NH];
  int m_idle[NH];
  bit m_done[NH];
  bit m_tout[NH];

  riscv_exec_ctrl #(
    .NUM_HARTS    (NH),
    .RST_CYCLES   (RC),
    .STEP_TIMEOUT (STO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ctrl_we      (ctrl_we),
    .ctrl_wdata   (ctrl_wdata),
    .hart_retire  (hart_retire),
    .halt_req     (halt_req),
    .core_en      (core_en),
    .core_rst     (core_rst),
    .hart_halted  (hart_halted),
    .step_done    (step_done),
    .step_timeout (step_timeout),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: applies the control rules to the inputs seen at a rising edge.
  task automatic model_step();
    for (int h = 0; h < NH; h++) begin
      bit sel;
      if (!rst_n) begin
        m_mode[h] = M_HALT; m_rst_left[h] = 0; m_latch[h] = 0;
        m_steps[h] = 0; m_idle[h] = 0; m_done[h] = 0; m_tout[h] = 0;
        continue;
      end
      m_done[h] = 0;
      sel = ctrl_we && ctrl_wdata[16+h];
      if (sel) m_tout[h] = 0;
      if (sel && ctrl_wdata[1]) begin
        m_mode[h] = M_RST; m_rst_left[h] = RC; m_latch[h] = ctrl_wdata[0];
      end else if (sel && m_mode[h] != M_RST) begin
        if (ctrl_wdata[0]) m_mode[h] = M_RUN;
        else if (m_mode[h] == M_HALT && ctrl_wdata[2]) begin
          m_mode[h] = M_STEP; m_steps[h] = int'(ctrl_wdata[15:8]) + 1; m_idle[h] = 0;
        end else m_mode[h] = M_HALT;
      end else begin
        case (m_mode[h])
          M_RST: begin
            m_rst_left[h]--;
            if (m_rst_left[h] == 0) m_mode[h] = m_latch[h] ? M_RUN : M_HALT;
          end
          M_RUN: if (halt_req[h]) m_mode[h] = M_HALT;
          M_STEP: begin
            if (halt_req[h]) m_mode[h] = M_HALT;
            else if (hart_retire[h]) begin
              m_steps[h]--; m_idle[h] = 0;
              if (m_steps[h] == 0) begin m_mode[h] = M_HALT; m_done[h] = 1; end
            end else begin
`ifdef RISCV_EXEC_CTRL_STEP_WDOG_EN
              m_idle[h]++;
              if (m_idle[h] == STO) begin m_mode[h] = M_HALT; m_tout[h] = 1; end
`endif
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [NH-1:0] e_en, e_rst, e_hlt, e_done, e_tout;
    for (int h = 0; h < NH; h++) begin
      e_en[h]   = (m_mode[h] == M_RUN) || (m_mode[h] == M_STEP);
      e_rst[h]  = (m_mode[h] == M_RST);
      e_hlt[h]  = (m_mode[h] == M_HALT);
      e_done[h] = m_done[h];
      e_tout[h] = m_tout[h];
    end
    check({tag, ".core_en"},      32'(core_en),      32'(e_en));
    check({tag, ".core_rst"},     32'(core_rst),     32'(e_rst));
    check({tag, ".hart_halted"},  32'(hart_halted),  32'(e_hlt));
    check({tag, ".step_done"},    32'(step_done),    32'(e_done));
    check({tag, ".step_timeout"}, 32'(step_timeout), 32'(e_tout));
  endtask

  // driver tasks
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic do_write(input logic [31:0] w, input string tag);
    ctrl_we = 1'b1; ctrl_wdata = w;
    tick(tag);
    ctrl_we = 1'b0; ctrl_wdata = '0;
  endtask

  task automatic retire0(input string tag);
    hart_retire = 2'b01;
    tick(tag);
    hart_retire = '0;
  endtask

  initial begin
    rst_n = 1'b0; ctrl_we = 1'b0; ctrl_wdata = '0; hart_retire = '0; halt_req = '0;
    tick("reset"); tick("reset");
    check("reset.halted_all", 32'(hart_halted), 32'h3);
    check("reset.core_en", 32'(core_en), 32'h0);
    check("reset.core_rst", 32'(core_rst), 32'h0);
    check("reset.dbg_state", 32'(dbg_state), 32'h0);
    rst_n = 1'b1;
    tick("idle");

    // hart0 reset pulse then run
    do_write(32'h0001_0003, "rst_run");
    check("rst_run.core_rst0_c0", 32'(core_rst), 32'h1);
    for (int i = 1; i < RC; i++) begin
      tick("rst_run.pulse");
      check("rst_run.core_rst0_hold", 32'(core_rst), 32'h1);
    end
    tick("rst_run.exit");
    check("rst_run.core_en0", 32'(core_en), 32'h1);
    check("rst_run.core_rst_low", 32'(core_rst), 32'h0);
    check("rst_run.hart1_halted", 32'(hart_halted[1]), 32'h1);

    // masks that select nothing
    do_write(32'hFFFC_0003, "mask_high");
    do_write(32'h0000_0003, "mask_zero");
    check("mask.core_en", 32'(core_en), 32'h1);

    // hart1 to RUNNING, then write-over-halt priority and halt_req
    do_write(32'h0002_0001, "h1_run");
    halt_req = 2'b10;
    do_write(32'h0002_0001, "h1_prio");
    check("h1_prio.core_en1", 32'(core_en[1]), 32'h1);
    tick("h1_halt");
    check("h1_halt.halted1", 32'(hart_halted[1]), 32'h1);
    halt_req = '0;

    // hart0 three-instruction step
    do_write(32'h0001_0000, "h0_halt");
    do_write(32'h0001_0204, "step3");
    check("step3.core_en0", 32'(core_en[0]), 32'h1);
    retire0("step3.r1"); tick("step3.gap");
    retire0("step3.r2");
    retire0("step3.r3");
    check("step3.done", 32'(step_done), 32'h1);
    check("step3.core_en0_off", 32'(core_en[0]), 32'h0);
    check("step3.halted0", 32'(hart_halted[0]), 32'h1);
    tick("step3.after");
    check("step3.done_pulse", 32'(step_done), 32'h0);

    // stop a step by write; later retires ignored
    do_write(32'h0001_0504, "step_abort");
    retire0("step_abort.r1");
    do_write(32'h0001_0000, "step_abort.halt");
    for (int i = 0; i < 3; i++) retire0("step_abort.late");
    check("step_abort.no_done", 32'(step_done), 32'h0);
    check("step_abort.halted0", 32'(hart_halted[0]), 32'h1);

    // reset rewritten mid-pulse restarts the count with the new RUN latch
    do_write(32'h0001_0002, "rst_restart");
    tick("rst_restart.w1");
    do_write(32'h0001_0001, "rst_restart.ignored");
    do_write(32'h0001_0003, "rst_restart.rewrite");
    for (int i = 1; i < RC; i++) tick("rst_restart.pulse");
    check("rst_restart.still_rst", 32'(core_rst[0]), 32'h1);
    tick("rst_restart.exit");
    check("rst_restart.running", 32'(core_en[0]), 32'h1);
    do_write(32'h0001_0000, "rst_restart.halt");

    // step with no retire: watchdog (if built) or indefinite wait
    do_write(32'h0001_0004, "wdog.step");
    for (int i = 1; i < 16; i++) tick("wdog.wait");
    check("wdog.still_stepping", 32'(core_en[0]), 32'h1);
    tick("wdog.edge");
`ifdef RISCV_EXEC_CTRL_STEP_WDOG_EN
    check("wdog.timeout", 32'(step_timeout), 32'h1);
    check("wdog.halted0", 32'(hart_halted[0]), 32'h1);
    check("wdog.no_done", 32'(step_done), 32'h0);
    do_write(32'h0001_0000, "wdog.clear");
    check("wdog.cleared", 32'(step_timeout), 32'h0);
`else
    for (int i = 0; i < 24; i++) tick("wdog.wait_more");
    check("wdog.waiting", 32'(core_en[0]), 32'h1);
    check("wdog.tied0", 32'(step_timeout), 32'h0);
    do_write(32'h0001_0000, "wdog.halt");
`endif

    // synchronous reset during RESETTING, then during STEPPING
    do_write(32'h0001_0003, "sr_rst");
    tick("sr_rst.mid");
    rst_n = 1'b0;
    tick("sr_rst.assert");
    check("sr_rst.halted", 32'(hart_halted), 32'h3);
    check("sr_rst.core_rst", 32'(core_rst), 32'h0);
    rst_n = 1'b1;
    do_write(32'h0001_0304, "sr_step");
    do_write(32'h0002_0001, "sr_step.h1");
    retire0("sr_step.r1");
    rst_n = 1'b0; hart_retire = 2'b01;
    tick("sr_step.assert");
    hart_retire = '0;
    check("sr_step.halted", 32'(hart_halted), 32'h3);
    check("sr_step.no_done", 32'(step_done), 32'h0);
    rst_n = 1'b1;

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      logic [31:0] w;
      w = '0;
      w[16 +: 2]  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) w[31:18] = 14'($urandom);
      w[2:0]      = 3'($urandom_range(0, 7));
      w[15:8]     = 8'($urandom_range(0, 4));
      ctrl_we     = ($urandom_range(0, 9) == 0);
      ctrl_wdata  = ctrl_we ? w : 32'($urandom);
      hart_retire = NH'($urandom_range(0, 3));
      for (int h = 0; h < NH; h++) halt_req[h] = ($urandom_range(0, 24) == 0);
      rst_n       = ($urandom_range(0, 299) != 0);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
